vector_load_assembler: RTL and testbench

Upstream feeder for the 16 x 192-bit vector register file. It accepts a vector-load command (base address and destination register) and fetches six consecutive 32-bit words from data memory, one outstanding request at a time. It packs the words into one 192-bit vector and issues a single-cycle write (RD/WD/wr_enable style) into the register file.

---
 rtl/vector_load_assembler.sv | 139 +++++++++++++
 tb/tb_vector_load_assembler.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/vector_load_assembler.sv
// Fetches BEATS consecutive MEM_W words from data memory and writes them as one DATA_W vector into the register file.
// Optional macro VLOAD_TIMEOUT_EN aborts a load when a beat waits TIMEOUT cycles for mem_valid; err stays 0 when it is undefined.
module vector_load_assembler #(
   parameter int DATA_W = 192,
   parameter int MEM_W  = 32,
   parameter int ADDR_W = 32,
   parameter int REG_AW = 4
`ifdef VLOAD_TIMEOUT_EN
   , parameter int TIMEOUT = 64
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [REG_AW-1:0] dest_reg,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_rd_en,
   input  logic [MEM_W-1:0]  mem_rdata,
   input  logic              mem_valid,
   output logic [REG_AW-1:0] wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic              wb_en,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam int BEATS = DATA_W / MEM_W;
   localparam int BW    = $clog2(BEATS);

   typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WB} state_t;

   state_t            state_q, state_d;
   logic [BW-1:0]     beat_q, beat_d;
   logic [ADDR_W-1:0] base_q, base_d;
   logic [REG_AW-1:0] dest_q, dest_d;
   logic [DATA_W-1:0] buf_q, buf_d;

`ifdef VLOAD_TIMEOUT_EN
   localparam int WW = $clog2(TIMEOUT + 1);
   logic [WW-1:0] wait_q, wait_d;
   logic          err_q, err_d;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         beat_q  <= '0;
         base_q  <= '0;
         dest_q  <= '0;
         buf_q   <= '0;
`ifdef VLOAD_TIMEOUT_EN
         wait_q  <= '0;
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         beat_q  <= beat_d;
         base_q  <= base_d;
         dest_q  <= dest_d;
         buf_q   <= buf_d;
`ifdef VLOAD_TIMEOUT_EN
         wait_q  <= wait_d;
         err_q   <= err_d;
`endif
      end
   end

   always_comb begin
      state_d = state_q;
      beat_d  = beat_q;
      base_d  = base_q;
      dest_d  = dest_q;
      buf_d   = buf_q;
`ifdef VLOAD_TIMEOUT_EN
      wait_d  = wait_q;
      err_d   = 1'b0;
`endif
      case (state_q)
         S_IDLE: begin
            if (start) begin
               base_d  = base_addr;
               dest_d  = dest_reg;
               beat_d  = '0;
               buf_d   = '0;
               state_d = S_FETCH;
`ifdef VLOAD_TIMEOUT_EN
               wait_d  = '0;
`endif
            end
         end
         S_FETCH: begin
            if (mem_valid) begin
               // Beat 0 lands in the least significant word of the vector.
               buf_d[int'(beat_q)*MEM_W +: MEM_W] = mem_rdata;
               if (beat_q == BW'(BEATS - 1)) begin
                  state_d = S_WB;
               end else begin
                  beat_d = beat_q + 1'b1;
               end
`ifdef VLOAD_TIMEOUT_EN
               wait_d = '0;
`endif
            end
`ifdef VLOAD_TIMEOUT_EN
            else if (wait_q == WW'(TIMEOUT - 1)) begin
               state_d = S_IDLE;
               err_d   = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
`endif
         end
         S_WB: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // Address wraps modulo 2^ADDR_W through plain truncating addition.
   assign mem_addr  = base_q + ADDR_W'({beat_q, 2'b00});
   assign mem_rd_en = (state_q == S_FETCH);
   assign wb_en     = (state_q == S_WB);
   assign done      = (state_q == S_WB);
   assign busy      = (state_q != S_IDLE);
   assign wb_data   = buf_q;
   assign wb_rd     = dest_q;

`ifdef VLOAD_TIMEOUT_EN
   assign err = err_q;
`else
   assign err = 1'b0;
`endif

endmodule

// File: tb/tb_vector_load_assembler.sv
// Directed bench for vector_load_assembler: zero-wait loads, wait states, ignored starts, reset abort and address wrap.
module tb_vector_load_assembler;

   logic         clk = 1'b0;
   logic         rst;
   logic         start;
   logic [31:0]  base_addr;
   logic [3:0]   dest_reg;
   logic [31:0]  mem_addr;
   logic         mem_rd_en;
   logic [31:0]  mem_rdata;
   logic         mem_valid;
   logic [3:0]   wb_rd;
   logic [191:0] wb_data;
   logic         wb_en;
   logic         busy;
   logic         done;
   logic         err;

   int n_asserts = 0;
   int n_fail    = 0;
   int cyc       = 0;
   int wb_count  = 0;
   int exp_wb    = 0;
   logic [191:0] last_vec;

   vector_load_assembler dut (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .base_addr (base_addr),
      .dest_reg  (dest_reg),
      .mem_addr  (mem_addr),
      .mem_rd_en (mem_rd_en),
      .mem_rdata (mem_rdata),
      .mem_valid (mem_valid),
      .wb_rd     (wb_rd),
      .wb_data   (wb_data),
      .wb_en     (wb_en),
      .busy      (busy),
      .done      (done),
      .err       (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc++;
      if (wb_en === 1'b1) wb_count++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [191:0] obs, input logic [191:0] exp);
      n_asserts++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Entered at the falling edge of a FETCH cycle; leaves at the falling edge after the beat is accepted.
   task automatic do_beat(input logic [31:0] exp_addr, input logic [31:0] d, input int waits, input bit glitch);
      for (int w = 0; w < waits; w++) begin
         chk("wait_rd_en", 192'(mem_rd_en), 192'(1'b1));
         chk("wait_addr", 192'(mem_addr), 192'(exp_addr));
         mem_valid = 1'b0;
         @(negedge clk);
      end
      chk("rd_en", 192'(mem_rd_en), 192'(1'b1));
      chk("addr", 192'(mem_addr), 192'(exp_addr));
      chk("err_low", 192'(err), 192'(1'b0));
      mem_valid = 1'b1;
      mem_rdata = d;
      if (glitch) begin
         start    = 1'b1;
         dest_reg = 4'd4;
      end
      @(negedge clk);
      mem_valid = 1'b0;
      start     = 1'b0;
   endtask

   task automatic run_load(input logic [31:0] base, input logic [3:0] dest, input int wait_beat,
                           input int waits, input int glitch_beat, input logic [31:0] salt);
      logic [191:0] exp_vec;
      logic [31:0]  d;
      int           cyc0;
      exp_vec   = '0;
      start     = 1'b1;
      base_addr = base;
      dest_reg  = dest;
      cyc0      = cyc;
      @(negedge clk);
      start     = 1'b0;
      base_addr = 32'hDEAD_BEEF;
      dest_reg  = 4'hF;
      chk("busy_fetch", 192'(busy), 192'(1'b1));
      for (int i = 0; i < 6; i++) begin
         d = 32'h1111_1111 * (i + 1) + salt;
         exp_vec[32*i +: 32] = d;
         do_beat(base + 32'(4 * i), d, (i == wait_beat) ? waits : 0, i == glitch_beat);
      end
      chk("wb_en", 192'(wb_en), 192'(1'b1));
      chk("done", 192'(done), 192'(1'b1));
      chk("rd_en_wb", 192'(mem_rd_en), 192'(1'b0));
      chk("wb_rd", 192'(wb_rd), 192'(dest));
      chk("wb_data", wb_data, exp_vec);
      chk("latency", 192'(cyc - cyc0), 192'(7 + waits));
      last_vec = exp_vec;
      // A start in the writeback cycle must be dropped.
      start = 1'b1;
      base_addr = 32'h0000_4000;
      @(negedge clk);
      start = 1'b0;
      exp_wb++;
      chk("wb_en_off", 192'(wb_en), 192'(1'b0));
      chk("done_off", 192'(done), 192'(1'b0));
      chk("busy_idle", 192'(busy), 192'(1'b0));
      chk("rd_en_idle", 192'(mem_rd_en), 192'(1'b0));
      chk("wb_count", 192'(wb_count), 192'(exp_wb));
      @(negedge clk);
   endtask

   initial begin
      rst       = 1'b1;
      start     = 1'b0;
      base_addr = '0;
      dest_reg  = '0;
      mem_rdata = '0;
      mem_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_busy", 192'(busy), 192'(1'b0));
      chk("rst_rd_en", 192'(mem_rd_en), 192'(1'b0));
      chk("rst_wb_en", 192'(wb_en), 192'(1'b0));
      chk("rst_done", 192'(done), 192'(1'b0));
      chk("rst_err", 192'(err), 192'(1'b0));
      chk("rst_addr", 192'(mem_addr), 192'(32'h0));
      chk("rst_wb_data", wb_data, 192'(0));
      chk("rst_wb_rd", 192'(wb_rd), 192'(4'd0));
      rst = 1'b0;
      @(negedge clk);

      // Basic load, hand-computed endpoints first.
      run_load(32'h0000_0100, 4'd7, -1, 0, -1, 32'h0);
      chk("basic_lo", 192'(wb_data[31:0]), 192'(32'h1111_1111));
      chk("basic_hi", 192'(wb_data[191:160]), 192'(32'h6666_6666));
      $display("load basic base=100 dest=7 done");

      // mem_valid in IDLE must not touch the buffer.
      mem_valid = 1'b1;
      mem_rdata = 32'hABCD_ABCD;
      @(negedge clk);
      mem_valid = 1'b0;
      chk("idle_valid_busy", 192'(busy), 192'(1'b0));
      chk("idle_valid_data", wb_data, last_vec);
      $display("mem_valid in idle ignored");

      // Three wait cycles on beat 2.
      run_load(32'h0000_0100, 4'd0, 2, 3, -1, 32'h0000_0001);
      $display("load wait-state beat2 dest=0 done");

      // Start pulsed mid-fetch is ignored.
      run_load(32'h0000_0100, 4'd7, -1, 0, 3, 32'h0000_0002);
      $display("load with mid-fetch start done");

      // Reset after beat 3 is accepted.
      start     = 1'b1;
      base_addr = 32'h0000_0200;
      dest_reg  = 4'd3;
      @(negedge clk);
      start = 1'b0;
      for (int i = 0; i < 4; i++) do_beat(32'h0000_0200 + 32'(4 * i), 32'h5A5A_0000 + 32'(i), 0, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("abort_busy", 192'(busy), 192'(1'b0));
      chk("abort_rd_en", 192'(mem_rd_en), 192'(1'b0));
      chk("abort_wb_en", 192'(wb_en), 192'(1'b0));
      chk("abort_addr", 192'(mem_addr), 192'(32'h0));
      repeat (10) @(negedge clk);
      chk("abort_no_wb", 192'(wb_count), 192'(exp_wb));
      $display("reset mid-fetch aborted");
      run_load(32'h0000_0300, 4'd9, -1, 0, -1, 32'h0000_0003);
      $display("load after reset done");

      // Address wrap.
      run_load(32'hFFFF_FFF8, 4'd15, -1, 0, -1, 32'h0000_0004);
      $display("load wrap base=FFFFFFF8 done");

      chk("err_never", 192'(err), 192'(1'b0));
      $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
      $finish;
   end

endmodule
